// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron.
// Each enabled clock performs one neuron update:
// - In ACCUM, the membrane potential leaks, integrates input_current and saturates.
//   When the result reaches threshold, the neuron fires.
// - In REFRACTORY, updates are ignored for refractory_period enabled clocks.
// spike_out is a registered one-clock pulse.
// membrane_potential is the v register itself.
//
// Handshake: there is no valid/ready pair. enable acts as a valid-only strobe with
// implicit ready. Each rising edge with enable=1 consumes input_current, threshold,
// decay_shift and (when firing) refractory_period. Results appear one clock later.
// With enable=0, all state is held and spike_out returns to 0.

module lif_neuron #(
  parameter int W  = 8,
  parameter int RW = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic signed [W-1:0] input_current,
  input  logic signed [W-1:0] threshold,
  input  logic [2:0]          decay_shift,
  input  logic [RW-1:0]       refractory_period,
  output logic signed [W-1:0] membrane_potential,
  output logic                spike_out,
  output logic                refractory,
  output logic [0:0]          state_dbg
);

  localparam logic [0:0] ACCUM      = 1'b0;
  localparam logic [0:0] REFRACTORY = 1'b1;

  // Two guard bits hold any v - leak + input_current without overflow.
  localparam int SW = W + 2;
  localparam logic signed [SW-1:0] SAT_MAX = {{3{1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{3{1'b1}}, {(W-1){1'b0}}};

  logic [0:0]          state;
  logic signed [W-1:0] v;
  logic [RW-1:0]       count;
  logic                spike;

  logic signed [SW-1:0] v_ext;
  logic signed [SW-1:0] in_ext;
  logic signed [SW-1:0] leak;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sum_clamped;
  logic signed [W-1:0]  sat_v;
  logic                 fire;

  // Leak, integrate and saturate the candidate potential for an ACCUM update.
  always_comb begin
    v_ext  = {{2{v[W-1]}}, v};
    in_ext = {{2{input_current[W-1]}}, input_current};
    leak   = '0;
    if (decay_shift != 3'd0) begin
      leak = v_ext >>> decay_shift;
    end
    sum = v_ext - leak + in_ext;
    sum_clamped = sum;
    if (sum > SAT_MAX) begin
      sum_clamped = SAT_MAX;
    end else if (sum < SAT_MIN) begin
      sum_clamped = SAT_MIN;
    end
    sat_v = sum_clamped[W-1:0];
    fire  = (sat_v >= threshold);
  end

  // Neuron state update on each enabled edge; spike is cleared every clock unless firing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v     <= '0;
      spike <= 1'b0;
      count <= '0;
      state <= ACCUM;
    end else begin
      spike <= 1'b0;
      if (enable) begin
        case (state)
          ACCUM: begin
            if (fire) begin
              v     <= '0;
              spike <= 1'b1;
              if (refractory_period != '0) begin
                count <= refractory_period;
                state <= REFRACTORY;
              end
            end else begin
              v <= sat_v;
            end
          end
          REFRACTORY: begin
            v     <= '0;
            count <= count - RW'(1);
            if (count == RW'(1)) begin
              state <= ACCUM;
            end
          end
          default: begin
            state <= ACCUM;
          end
        endcase
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    membrane_potential = v;
    spike_out          = spike;
    refractory         = (state == REFRACTORY);
    state_dbg          = state;
  end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron with hand-computed expected values.
module tb_lif_neuron;

  localparam int W  = 8;
  localparam int RW = 8;

  logic                clk;
  logic                reset_n;
  logic                enable;
  logic signed [W-1:0] input_current;
  logic signed [W-1:0] threshold;
  logic [2:0]          decay_shift;
  logic [RW-1:0]       refractory_period;
  logic signed [W-1:0] membrane_potential;
  logic                spike_out;
  logic                refractory;
  logic [0:0]          state_dbg;

  int n_vec;
  int n_err;

  lif_neuron #(.W(W), .RW(RW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .input_current     (input_current),
    .threshold         (threshold),
    .decay_shift       (decay_shift),
    .refractory_period (refractory_period),
    .membrane_potential(membrane_potential),
    .spike_out         (spike_out),
    .refractory        (refractory),
    .state_dbg         (state_dbg)
  );

  // Clock and initial values.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare potential, spike and refractory flag together.
  task automatic check_out(input string tag, input int exp_v, input int exp_sp,
                           input int exp_rf);
    check($sformatf("%s.v", tag), membrane_potential, exp_v);
    check($sformatf("%s.spike", tag), spike_out, exp_sp);
    check($sformatf("%s.refr", tag), refractory, exp_rf);
  endtask

  // One clock with the given enable/current; sample 1 ns after the edge.
  task automatic upd(input logic en, input int cur);
    enable        = en;
    input_current = W'(cur);
    @(posedge clk);
    #1;
  endtask

  // Full reset, checked while held, plus one idle enable=0 clock after release.
  task automatic do_reset(input string tag);
    enable  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_out($sformatf("%s.in_reset", tag), 0, 0, 0);
    check($sformatf("%s.state", tag), state_dbg, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    upd(1'b0, 0);
  endtask

  // Directed sequence.
  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n           = 1'b0;
    enable            = 1'b0;
    input_current     = '0;
    threshold         = '0;
    decay_shift       = '0;
    refractory_period = '0;
    @(posedge clk);
    #1;
    check_out("por", 0, 0, 0);
    do_reset("init");

    // Integrate, fire, two ignored updates, then resume.
    threshold = 8'sd50; decay_shift = 3'd0; refractory_period = 8'd2;
    upd(1'b1, 20); check_out("fire.u1", 20, 0, 0);
    upd(1'b1, 20); check_out("fire.u2", 40, 0, 0);
    upd(1'b1, 20); check_out("fire.u3", 0, 1, 1);
    check("fire.state3", state_dbg, 1);
    upd(1'b1, 20); check_out("fire.u4", 0, 0, 1);
    upd(1'b1, 20); check_out("fire.u5", 0, 0, 0);
    upd(1'b1, 20); check_out("fire.u6", 20, 0, 0);

    // Leak from +100.
    do_reset("leakp");
    threshold = 8'sd127; decay_shift = 3'd0; refractory_period = 8'd0;
    upd(1'b1, 100); check_out("leakp.pre", 100, 0, 0);
    decay_shift = 3'd1;
    upd(1'b1, 0); check_out("leakp.1", 50, 0, 0);
    upd(1'b1, 0); check_out("leakp.2", 25, 0, 0);
    upd(1'b1, 0); check_out("leakp.3", 13, 0, 0);

    // Leak from -100.
    do_reset("leakn");
    decay_shift = 3'd0;
    upd(1'b1, -100); check_out("leakn.pre", -100, 0, 0);
    decay_shift = 3'd1;
    upd(1'b1, 0); check_out("leakn.1", -50, 0, 0);
    upd(1'b1, 0); check_out("leakn.2", -25, 0, 0);
    upd(1'b1, 0); check_out("leakn.3", -12, 0, 0);

    // Positive saturation reaching threshold 127.
    do_reset("satp");
    decay_shift = 3'd0; threshold = 8'sd127; refractory_period = 8'd0;
    upd(1'b1, 100); check_out("satp.1", 100, 0, 0);
    upd(1'b1, 100); check_out("satp.2", 0, 1, 0);

    // Negative saturation holds at -128.
    do_reset("satn");
    upd(1'b1, -128); check_out("satn.1", -128, 0, 0);
    upd(1'b1, -128); check_out("satn.2", -128, 0, 0);
    upd(1'b1, -128); check_out("satn.3", -128, 0, 0);

    // Enable gating.
    do_reset("gate");
    upd(1'b1, 20); check_out("gate.1", 20, 0, 0);
    upd(1'b0, 20); check_out("gate.2", 20, 0, 0);
    upd(1'b0, 20); check_out("gate.3", 20, 0, 0);
    upd(1'b1, 20); check_out("gate.4", 40, 0, 0);
    threshold = 8'sd50;
    upd(1'b1, 20); check_out("gate.fire", 0, 1, 0);
    upd(1'b0, 20); check_out("gate.off", 0, 0, 0);

    // Zero refractory period fires on every update.
    do_reset("zref");
    threshold = 8'sd10; refractory_period = 8'd0;
    for (int i = 0; i < 4; i++) begin
      upd(1'b1, 15);
      check_out($sformatf("zref.%0d", i), 0, 1, 0);
    end

    // Reset asserted partway through a refractory period.
    do_reset("rmid");
    threshold = 8'sd50; refractory_period = 8'd5;
    upd(1'b1, 20); check_out("rmid.u1", 20, 0, 0);
    upd(1'b1, 20); check_out("rmid.u2", 40, 0, 0);
    upd(1'b1, 20); check_out("rmid.fire", 0, 1, 1);
    upd(1'b1, 20); check_out("rmid.ign1", 0, 0, 1);
    upd(1'b1, 20); check_out("rmid.ign2", 0, 0, 1);
    reset_n = 1'b0;
    #1;
    check_out("rmid.async", 0, 0, 0);
    check("rmid.state", state_dbg, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    upd(1'b0, 20);
    upd(1'b1, 20); check_out("rmid.after", 20, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
